// File: rtl/lsu_mem_datos.sv
// ============================================================================
// lsu_mem_datos : load/store unit, initiator side of the Mem_Datos data memory.
//                 Sub-word stores use read-modify-write on a word-only memory.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_datos #(
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic        Resp_Valid,
    output logic [31:0] Resp_RData,
    output logic        Resp_Err,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_WriteData,
    output logic        Mem_Write_EN,
    input  logic [31:0] Mem_Read_Data
);

    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] lat_cnt;
    logic             is_write;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo;
    logic [15:0]      wdata_q;

    logic             req_err;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [31:0]      merged;

    // Stores only support B/H/W; unsigned variants are loads only.
    always_comb begin
        req_err = 1'b0;
        case (Req_Funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = Req_Addr[0];
            3'b010:  req_err = |Req_Addr[1:0];
            3'b100:  req_err = Req_Write;
            3'b101:  req_err = Req_Write | Req_Addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = Mem_Read_Data[7:0];
        case (addr_lo)
            2'd0:    byte_sel = Mem_Read_Data[7:0];
            2'd1:    byte_sel = Mem_Read_Data[15:8];
            2'd2:    byte_sel = Mem_Read_Data[23:16];
            default: byte_sel = Mem_Read_Data[31:24];
        endcase
        half_sel = addr_lo[1] ? Mem_Read_Data[31:16] : Mem_Read_Data[15:0];

        load_data = Mem_Read_Data;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = Mem_Read_Data;
        endcase
    end

    always_comb begin
        merged = Mem_Read_Data;
        if (funct3_q == 3'b000) begin
            merged[{addr_lo, 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_lo[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            is_write      <= 1'b0;
            funct3_q      <= 3'b000;
            addr_lo       <= 2'b00;
            wdata_q       <= 16'h0;
            Req_Ready     <= 1'b1;
            Resp_Valid    <= 1'b0;
            Resp_RData    <= 32'h0;
            Resp_Err      <= 1'b0;
            Mem_Address   <= 32'h0;
            Mem_WriteData <= 32'h0;
            Mem_Write_EN  <= 1'b0;
        end else begin
            Mem_Write_EN <= 1'b0;
            Resp_Valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        Req_Ready <= 1'b0;
                        is_write  <= Req_Write;
                        funct3_q  <= Req_Funct3;
                        addr_lo   <= Req_Addr[1:0];
                        wdata_q   <= Req_WData[15:0];
                        lat_cnt   <= '0;
                        if (req_err) begin
                            state      <= RESP;
                            Resp_Valid <= 1'b1;
                            Resp_Err   <= 1'b1;
                            Resp_RData <= 32'h0;
                        end else if (Req_Write && (Req_Funct3 == 3'b010)) begin
                            state         <= WR;
                            Mem_Address   <= {2'b00, Req_Addr[31:2]};
                            Mem_WriteData <= Req_WData;
                            Mem_Write_EN  <= 1'b1;
                        end else begin
                            state       <= RD_WAIT;
                            Mem_Address <= {2'b00, Req_Addr[31:2]};
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (is_write) begin
                            state         <= WR;
                            Mem_WriteData <= merged;
                            Mem_Write_EN  <= 1'b1;
                        end else begin
                            state      <= RESP;
                            Resp_Valid <= 1'b1;
                            Resp_RData <= load_data;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WR: begin
                    state      <= RESP;
                    Resp_Valid <= 1'b1;
                    Resp_RData <= 32'h0;
                    Resp_Err   <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    Req_Ready  <= 1'b1;
                    Resp_RData <= 32'h0;
                    Resp_Err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    Req_Ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_datos.sv
// Table-driven bench for lsu_mem_datos with a word-wide memory model of
// configurable read latency.
`default_nettype none

module tb_lsu_mem_datos;

    localparam int READ_LAT = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Write = 1'b0;
    logic [2:0]  Req_Funct3 = 3'b000;
    logic [31:0] Req_Addr = 32'h0;
    logic [31:0] Req_WData = 32'h0;
    logic        Resp_Valid;
    logic [31:0] Resp_RData;
    logic        Resp_Err;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_WriteData;
    logic        Mem_Write_EN;
    logic [31:0] Mem_Read_Data;

    lsu_mem_datos #(.READ_LAT(READ_LAT)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .Req_Valid     (Req_Valid),
        .Req_Ready     (Req_Ready),
        .Req_Write     (Req_Write),
        .Req_Funct3    (Req_Funct3),
        .Req_Addr      (Req_Addr),
        .Req_WData     (Req_WData),
        .Resp_Valid    (Resp_Valid),
        .Resp_RData    (Resp_RData),
        .Resp_Err      (Resp_Err),
        .Mem_Address   (Mem_Address),
        .Mem_WriteData (Mem_WriteData),
        .Mem_Write_EN  (Mem_Write_EN),
        .Mem_Read_Data (Mem_Read_Data)
    );

    always #5 CLK = ~CLK;

    // Memory model: 16 words, data valid READ_LAT cycles after the address settles.
    logic [31:0] mem [0:15];
    logic [31:0] rd_pipe [0:3];
    int          wr_count = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) rd_pipe[i] = 32'h0;
    end

    always @(posedge CLK) begin
        rd_pipe[0] <= mem[Mem_Address[3:0]];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        rd_pipe[3] <= rd_pipe[2];
        if (Mem_Write_EN) begin
            mem[Mem_Address[3:0]] <= Mem_WriteData;
            wr_count   <= wr_count + 1;
            last_waddr <= Mem_Address;
            last_wdata <= Mem_WriteData;
        end
    end

    assign Mem_Read_Data = (READ_LAT == 1) ? mem[Mem_Address[3:0]] : rd_pipe[READ_LAT-2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          writes;
        logic [31:0] waddr;
        logic [31:0] wval;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                                input logic err, input int writes, input logic [31:0] waddr,
                                input logic [31:0] wval);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat;
        v.rdata = rdata; v.err = err; v.writes = writes; v.waddr = waddr; v.wval = wval;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int idx);
        int  base_w;
        int  n;
        bit  done;
        bit  ready_bad;
        check($sformatf("v%0d ready_before", idx), {31'h0, Req_Ready}, 32'h1);
        base_w     = wr_count;
        Req_Valid  = 1'b1;
        Req_Write  = v.wr;
        Req_Funct3 = v.f3;
        Req_Addr   = v.addr;
        Req_WData  = v.wdata;
        @(negedge CLK);
        Req_Valid = 1'b0;
        n = 1;
        done = 1'b0;
        ready_bad = 1'b0;
        while (!done && n <= 20) begin
            if (Req_Ready) ready_bad = 1'b1;
            if (Resp_Valid) done = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        check($sformatf("v%0d latency", idx), n, v.lat);
        check($sformatf("v%0d rdata", idx), Resp_RData, v.rdata);
        check($sformatf("v%0d err", idx), {31'h0, Resp_Err}, {31'h0, v.err});
        check($sformatf("v%0d ready_low", idx), {31'h0, ready_bad}, 32'h0);
        @(negedge CLK);
        check($sformatf("v%0d resp_pulse", idx), {31'h0, Resp_Valid}, 32'h0);
        check($sformatf("v%0d writes", idx), wr_count - base_w, v.writes);
        if (v.writes > 0) begin
            check($sformatf("v%0d waddr", idx), last_waddr, v.waddr);
            check($sformatf("v%0d wdata", idx), last_wdata, v.wval);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int base_w;
        int resp_cyc[$];
        bit ready_bad;
        logic [31:0] rd1;
        logic [31:0] rd2;

        vecs.push_back(mk(1, 3'b010, 32'h4,        32'h00000002, 2, 32'h0,        0, 1, 32'h1, 32'h00000002));
        vecs.push_back(mk(0, 3'b010, 32'h4,        32'h0,        3, 32'h00000002, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h4,        32'h11223344, 2, 32'h0,        0, 1, 32'h1, 32'h11223344));
        vecs.push_back(mk(1, 3'b000, 32'h6,        32'h123456AB, 4, 32'h0,        0, 1, 32'h1, 32'h11AB3344));
        vecs.push_back(mk(0, 3'b000, 32'h6,        32'h0,        3, 32'hFFFFFFAB, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h6,        32'h0,        3, 32'h000000AB, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h6,        32'h0,        3, 32'h000011AB, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h4,        32'h0,        3, 32'h00003344, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h6,        32'h0,        1, 32'h0,        1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h5,        32'hFFFF,     1, 32'h0,        1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h0,        32'h0,        1, 32'h0,        1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h0,        32'h55,       1, 32'h0,        1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h0,        32'h0,        1, 32'h0,        1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h8,        32'h1234ABCD, 4, 32'h0,        0, 1, 32'h2, 32'h0000ABCD));
        vecs.push_back(mk(0, 3'b001, 32'h8,        32'h0,        3, 32'hFFFFABCD, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h9,        32'h0,        3, 32'hFFFFFFAB, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFC, 32'hCAFEF00D, 2, 32'h0,        0, 1, 32'h3FFFFFFF, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 32'h0,        3, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'hFFFFFFFD, 32'h0,        3, 32'hFFFFFFF0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'hFFFFFFFE, 32'h0,        3, 32'h0000CAFE, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h7,        32'h00000080, 4, 32'h0,        0, 1, 32'h1, 32'h80AB3344));
        vecs.push_back(mk(0, 3'b000, 32'h7,        32'h0,        3, 32'hFFFFFF80, 0, 0, 32'h0, 32'h0));

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst ready",   {31'h0, Req_Ready},    32'h1);
        check("rst valid",   {31'h0, Resp_Valid},   32'h0);
        check("rst err",     {31'h0, Resp_Err},     32'h0);
        check("rst rdata",   Resp_RData,            32'h0);
        check("rst addr",    Mem_Address,           32'h0);
        check("rst wdata",   Mem_WriteData,         32'h0);
        check("rst wen",     {31'h0, Mem_Write_EN}, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: Req_Valid held high across two loads
        resp_cyc.delete();
        ready_bad = 1'b0;
        rd1 = 32'h0;
        rd2 = 32'h0;
        Req_Valid  = 1'b1;
        Req_Write  = 1'b0;
        Req_Funct3 = 3'b010;
        Req_Addr   = 32'h4;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                Req_Funct3 = 3'b100;
                Req_Addr   = 32'h6;
            end
            if (n == 5) Req_Valid = 1'b0;
            if (Req_Ready !== ((n == 4) || (n >= 8) ? 1'b1 : 1'b0)) ready_bad = 1'b1;
            if (Resp_Valid) begin
                resp_cyc.push_back(n);
                if (resp_cyc.size() == 1) rd1 = Resp_RData;
                else rd2 = Resp_RData;
            end
        end
        check("b2b resp_count", resp_cyc.size(), 2);
        if (resp_cyc.size() == 2) begin
            check("b2b resp1_cycle", resp_cyc[0], 3);
            check("b2b resp2_cycle", resp_cyc[1], 7);
        end
        check("b2b rdata1", rd1, 32'h80AB3344);
        check("b2b rdata2", rd2, 32'h000000AB);
        check("b2b ready_pattern", {31'h0, ready_bad}, 32'h0);

        // Reset during the read phase of an SB aborts it without a write
        base_w     = wr_count;
        Req_Valid  = 1'b1;
        Req_Write  = 1'b1;
        Req_Funct3 = 3'b000;
        Req_Addr   = 32'h0;
        Req_WData  = 32'h5A;
        @(negedge CLK);
        Req_Valid = 1'b0;
        check("abort in_flight", {31'h0, Req_Ready}, 32'h0);
        #2 RST_N = 1'b0;
        #1;
        check("abort ready",  {31'h0, Req_Ready},    32'h1);
        check("abort valid",  {31'h0, Resp_Valid},   32'h0);
        check("abort addr",   Mem_Address,           32'h0);
        check("abort wdata",  Mem_WriteData,         32'h0);
        check("abort wen",    {31'h0, Mem_Write_EN}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort no_write", wr_count - base_w, 0);
        check("abort no_resp",  {31'h0, Resp_Valid}, 32'h0);
        check("abort mem0",     mem[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_datos.md
Name: lsu_mem_datos

Overview:
- Load/store unit for the RISC-V core: the initiator side of the data-memory interface (Mem_Datos).
- Accepts one load/store request at a time from the MEM stage and drives word-indexed Address/WriteData/Write_EN to the memory.
- Samples Read_Data from the memory and returns sign/zero-extended load data.
- Sub-word stores (SB/SH) use read-modify-write because the memory has only a full-word write enable.

Parameters:
- READ_LAT, 1, cycles between a stable Mem_Address and valid Mem_Read_Data (legal range 1..4).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- Req_Valid  input  1  request present.
- Req_Ready  output  1  unit can accept a request (high only in IDLE).
- Req_Write  input  1  1 = store, 0 = load.
- Req_Funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Req_Addr  input  32  byte address.
- Req_WData  input  32  store data; low bits used for B/H.
- Resp_Valid  output  1  one-cycle pulse: request complete.
- Resp_RData  output  32  extended load data; 0 for stores and errors.
- Resp_Err  output  1  misaligned address or illegal funct3; valid with Resp_Valid.
- Mem_Address  output  32  word index = {2'b00, addr[31:2]}.
- Mem_WriteData  output  32  word to write.
- Mem_Write_EN  output  1  memory write enable.
- Mem_Read_Data  input  32  word read from memory.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE; Req_Ready=1; Resp_Valid=0; Resp_Err=0; Resp_RData, Mem_Address, Mem_WriteData all 0; Mem_Write_EN=0.
- A reset asserted mid-operation aborts the request: no write, no response.
- Memory-side outputs are registered.
- FSM states: IDLE, RD_WAIT, WR, RESP.
- IDLE, on Req_Valid=1: latch all Req_* fields and check the request.
  - Error conditions:
    - funct3 is 011, 110 or 111 (also illegal for stores: 100, 101).
    - Halfword access with addr[0]=1.
    - Word access with addr[1:0]!=0.
  - Error -> RESP with Err=1. No memory access.
  - SW -> WR.
  - Load, SB or SH -> RD_WAIT.
- RD_WAIT: hold Mem_Address for READ_LAT cycles.
  - Capture Mem_Read_Data on the last cycle.
  - Load -> RESP.
  - SB/SH -> WR.
- WR: Mem_Write_EN=1 for exactly one cycle, then -> RESP.
  - SW: Mem_WriteData = Req_WData.
  - SB: captured word with byte lane addr[1:0] replaced by WData[7:0].
  - SH: captured word with half lane addr[1] replaced by WData[15:0].
- RESP: Resp_Valid=1 for one cycle, then -> IDLE.
  - Load extraction: byte/half selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency, counted from the acceptance edge:
  - Load: Resp_Valid READ_LAT+1 cycles later.
  - SW: 2 cycles.
  - SB/SH: READ_LAT+2 cycles.
  - Error: 1 cycle.
- No pipelining: Req_Ready=0 from acceptance until Resp_Valid falls.
  - Req_Valid held high in RESP is accepted in the following IDLE cycle.
- Mem_Write_EN is 0 in every state except WR. Writes never occur for loads or errors.
- Address wrap: addr 0xFFFFFFFC gives word index 0x3FFFFFFF; no overflow handling needed.

Test Plan:
- Reset → outputs: assert RST_N=0 mid-cycle during an SB's RD_WAIT → Mem_Write_EN never pulses; all outputs 0; Req_Ready=1 immediately.
- SW then LW: SW addr 0x4, data 0x00000002 → one Write_EN pulse with Mem_Address=1, Resp_Valid 2 cycles after accept. LW addr 0x4 → Resp_RData=0x00000002 at READ_LAT+1 cycles.
- SB read-modify-write: memory word 1 = 0x11223344; SB addr 0x6, data 0xAB → Mem_WriteData=0x11AB3344 written once.
- Loads of word 0x11AB3344:
  - LB addr 0x6 → 0xFFFFFFAB.
  - LBU → 0x000000AB.
  - LH addr 0x6 → 0x000011AB.
- Misalignment:
  - LW addr 0x6 → Resp_Err=1 at 1 cycle, Resp_RData=0, no memory activity.
  - SH addr 0x5 → Resp_Err=1, no write.
  - funct3=011 → Resp_Err=1.
- Back-to-back with READ_LAT=2: Req_Valid held high for two loads → second accepted the cycle after the first Resp_Valid; Req_Ready low throughout each operation.
